// File: rtl/fifo_pkt_pkg.sv
// Shared constants and beat side-band layout for the packet FIFO wrapper.
package fifo_pkt_pkg;

  localparam int unsigned EMPTY_W = 6;
  localparam int unsigned CSR_DW  = 32;
  localparam int unsigned CSR_AW  = 3;
  localparam int unsigned META_W  = 8;

  localparam logic [CSR_AW-1:0] CSR_FILL_LEVEL = 3'd0;

  // Side-band stored next to the data in the upper bits of each RAM word.
  typedef struct packed {
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } pkt_meta_t;

endpackage

// File: rtl/fifo_pkt_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module fifo_pkt_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register doubles as the FIFO's show-ahead output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_pkt_wrapper_infill.sv
// Show-ahead packet FIFO with a fill-level CSR. Optional simulation trace
// of pushes/pops is enabled with the FIFO_TRACE_EN macro.
module fifo_pkt_wrapper_infill
  import fifo_pkt_pkg::*;
#(
  parameter int unsigned SYMBOLS_PER_BEAT = 64,
  parameter int unsigned BITS_PER_SYMBOL  = 8,
  parameter int unsigned FIFO_DEPTH       = 512,
  parameter int unsigned USE_PACKETS      = 1,
  localparam int unsigned DW              = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL
) (
  input  logic               clk,
  input  logic               reset_n,

  input  logic [CSR_AW-1:0]  csr_address,
  input  logic               csr_read,
  input  logic               csr_write,
  input  logic [CSR_DW-1:0]  csr_writedata,
  output logic [CSR_DW-1:0]  csr_readdata,

  input  logic [DW-1:0]      in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_startofpacket,
  input  logic               in_endofpacket,
  input  logic [EMPTY_W-1:0] in_empty,

  output logic [DW-1:0]      out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [EMPTY_W-1:0] out_empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = DW + META_W;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fill_level;
  logic [CW-1:0] fill_next_c;
  logic          accept_c;
  logic          pop_c;
  logic          ram_has_data_c;
  logic          rd_en_c;
  pkt_meta_t     in_meta_c;
  pkt_meta_t     out_meta_c;
  logic [RW-1:0] wr_word_c;
  logic [RW-1:0] rd_word;

  assign accept_c = in_valid && in_ready;
  assign pop_c    = out_valid && out_ready;

  // Beats still in the RAM are the fill level minus the one in the output stage.
  assign ram_has_data_c = (fill_level != CW'(out_valid));
  assign rd_en_c        = ram_has_data_c && (!out_valid || out_ready);

  always_comb begin
    fill_next_c = fill_level;
    case ({accept_c, pop_c})
      2'b10:   fill_next_c = fill_level + CW'(1);
      2'b01:   fill_next_c = fill_level - CW'(1);
      default: fill_next_c = fill_level;
    endcase
  end

  // Pointers, occupancy, ready/valid flags and the CSR read register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_level   <= '0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      csr_readdata <= '0;
    end else begin
      if (accept_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fill_level <= fill_next_c;
      in_ready   <= (fill_next_c < CW'(FIFO_DEPTH));
      if (rd_en_c) begin
        out_valid <= 1'b1;
      end else if (pop_c) begin
        out_valid <= 1'b0;
      end
      if (csr_read) begin
        csr_readdata <= (csr_address == CSR_FILL_LEVEL) ? CSR_DW'(fill_level) : '0;
      end
    end
  end

  // CSR writes are accepted but have no effect.
  logic unused_csr;
  assign unused_csr = &{1'b0, csr_write, csr_writedata};

  assign wr_word_c  = {in_meta_c, in_data};
  assign out_data   = rd_word[DW-1:0];
  assign out_meta_c = rd_word[RW-1:DW];

  generate
    if (USE_PACKETS != 0) begin : g_pkt
      assign in_meta_c         = '{sop: in_startofpacket, eop: in_endofpacket, empty: in_empty};
      assign out_startofpacket = out_meta_c.sop;
      assign out_endofpacket   = out_meta_c.eop;
      assign out_empty         = out_meta_c.empty;
    end else begin : g_nopkt
      logic unused_pkt;
      assign unused_pkt        = &{1'b0, in_startofpacket, in_endofpacket, in_empty, out_meta_c};
      assign in_meta_c         = '0;
      assign out_startofpacket = 1'b0;
      assign out_endofpacket   = 1'b0;
      assign out_empty         = '0;
    end
  endgenerate

  fifo_pkt_ram #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset_n),
    .we    (accept_c),
    .waddr (wr_ptr),
    .wdata (wr_word_c),
    .re    (rd_en_c),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

`ifdef FIFO_TRACE_EN
  logic [31:0] trace_cycle;
  logic        trace_push_q;
  logic        trace_pop_q;

  // Cycle-stamped push/pop log; a run marker precedes each back-to-back burst.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trace_cycle  <= '0;
      trace_push_q <= 1'b0;
      trace_pop_q  <= 1'b0;
    end else begin
      trace_cycle  <= trace_cycle + 32'd1;
      trace_push_q <= accept_c;
      trace_pop_q  <= pop_c;
      if (accept_c) begin
        if (!trace_push_q) begin
          $display("+ PKT PUSH");
        end
        $display("PUSH cycle=%0d fill=%0d", trace_cycle, fill_next_c);
      end
      if (pop_c) begin
        if (!trace_pop_q) begin
          $display("- PKT POP");
        end
        $display("POP cycle=%0d fill=%0d", trace_cycle, fill_next_c);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_pkt_wrapper_infill.sv
// Directed bench for fifo_pkt_wrapper_infill with an ordering scoreboard.
module tb_fifo_pkt_wrapper_infill;

  localparam int unsigned DW    = 512;
  localparam int unsigned CKW   = DW + 8;
  localparam int unsigned NP_DW = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [2:0]       csr_address;
  logic             csr_read;
  logic             csr_write;
  logic [31:0]      csr_writedata;
  logic [31:0]      csr_readdata;
  logic [DW-1:0]    in_data;
  logic             in_valid;
  logic             in_ready;
  logic             in_startofpacket;
  logic             in_endofpacket;
  logic [5:0]       in_empty;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_startofpacket;
  logic             out_endofpacket;
  logic [5:0]       out_empty;

  logic [31:0]      np_csr_readdata;
  logic [NP_DW-1:0] np_in_data;
  logic             np_in_valid;
  logic             np_in_ready;
  logic             np_in_sop;
  logic             np_in_eop;
  logic [5:0]       np_in_empty;
  logic [NP_DW-1:0] np_out_data;
  logic             np_out_valid;
  logic             np_out_ready;
  logic             np_out_sop;
  logic             np_out_eop;
  logic [5:0]       np_out_empty;

  int unsigned      n_vec   = 0;
  int unsigned      n_err   = 0;
  int unsigned      acc_cnt = 0;
  int unsigned      pop_cnt = 0;
  logic [31:0]      seq;
  logic [CKW-1:0]   exp_q[$];
  logic             hold_chk = 1'b0;
  logic [CKW-1:0]   held;
  logic [CKW-1:0]   in_word;
  logic [CKW-1:0]   out_word;

  assign in_word  = {in_startofpacket, in_endofpacket, in_empty, in_data};
  assign out_word = {out_startofpacket, out_endofpacket, out_empty, out_data};

  always #5 clk = ~clk;

  fifo_pkt_wrapper_infill u_dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .csr_address       (csr_address),
    .csr_read          (csr_read),
    .csr_write         (csr_write),
    .csr_writedata     (csr_writedata),
    .csr_readdata      (csr_readdata),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_empty          (in_empty),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_empty         (out_empty)
  );

  fifo_pkt_wrapper_infill #(
    .SYMBOLS_PER_BEAT (4),
    .BITS_PER_SYMBOL  (8),
    .FIFO_DEPTH       (4),
    .USE_PACKETS      (0)
  ) u_np (
    .clk               (clk),
    .reset_n           (reset_n),
    .csr_address       (3'd0),
    .csr_read          (1'b0),
    .csr_write         (1'b0),
    .csr_writedata     (32'd0),
    .csr_readdata      (np_csr_readdata),
    .in_data           (np_in_data),
    .in_valid          (np_in_valid),
    .in_ready          (np_in_ready),
    .in_startofpacket  (np_in_sop),
    .in_endofpacket    (np_in_eop),
    .in_empty          (np_in_empty),
    .out_data          (np_out_data),
    .out_valid         (np_out_valid),
    .out_ready         (np_out_ready),
    .out_startofpacket (np_out_sop),
    .out_endofpacket   (np_out_eop),
    .out_empty         (np_out_empty)
  );

  task automatic check(input string tag, input logic [CKW-1:0] obs, input logic [CKW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input logic [31:0] s);
    logic [DW-1:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = s ^ (32'(w) << 24);
    return d;
  endfunction

  task automatic drive_beat(input logic [31:0] s);
    in_data          = mk_data(s);
    in_startofpacket = s[0];
    in_endofpacket   = s[1];
    in_empty         = s[7:2];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one clock; move to the next beat only if the current one was taken.
  task automatic step();
    logic acc;
    acc = in_valid && in_ready;
    tick();
    if (acc) begin
      seq = seq + 32'd1;
      drive_beat(seq);
    end
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    csr_address = a;
    csr_read    = 1'b1;
    tick();
    csr_read    = 1'b0;
    d           = csr_readdata;
  endtask

  // Scoreboard and show-ahead stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (hold_chk) check("hold_stable", out_word, held);
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) check("pop_underflow", CKW'(1), CKW'(0));
        else check("pop_order", out_word, exp_q.pop_front());
      end
      hold_chk = out_valid && !out_ready;
      held     = out_word;
      if (in_valid && in_ready) begin
        acc_cnt++;
        exp_q.push_back(in_word);
      end
    end else begin
      hold_chk = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0]    rd;
    logic [CKW-1:0] beat_d;
    int unsigned    a0;
    int unsigned    p0;
    int unsigned    c;

    reset_n = 1'b0; csr_address = '0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = '0;
    in_data = '0; in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0; in_empty = '0;
    out_ready = 1'b0; seq = '0;
    np_in_data = '0; np_in_valid = 1'b0; np_in_sop = 1'b0; np_in_eop = 1'b0; np_in_empty = '0;
    np_out_ready = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_out_valid", CKW'(out_valid), CKW'(0));
    check("rst_in_ready", CKW'(in_ready), CKW'(0));
    check("rst_csr", CKW'(csr_readdata), CKW'(0));
    check("rst_out_word", out_word, CKW'(0));
    check("rst_np_ready", CKW'(np_in_ready), CKW'(0));
    reset_n = 1'b1;
    tick();
    check("ready_after_rst", CKW'(in_ready), CKW'(1));
    check("np_ready_after_rst", CKW'(np_in_ready), CKW'(1));

    // Single beat into an empty FIFO: sop=eop=1, empty=5
    seq = 32'd23;
    drive_beat(seq);
    beat_d = {1'b1, 1'b1, 6'd5, mk_data(32'd23)};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("lat_edge1_valid", CKW'(out_valid), CKW'(0));
    tick();
    check("lat_edge2_valid", CKW'(out_valid), CKW'(1));
    check("lat_edge2_word", out_word, beat_d);
    csr_rd(3'd0, rd);
    check("csr_fill_1", CKW'(rd), CKW'(1));
    csr_rd(3'd5, rd);
    check("csr_other_addr", CKW'(rd), CKW'(0));
    csr_write = 1'b1; csr_writedata = 32'hFFFF_FFFF; csr_address = 3'd0;
    tick();
    csr_write = 1'b0;
    csr_rd(3'd0, rd);
    check("csr_write_ignored", CKW'(rd), CKW'(1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("empty_valid", CKW'(out_valid), CKW'(0));
    check("empty_hold_word", out_word, beat_d);
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    csr_rd(3'd0, rd);
    check("empty_pop_noeffect", CKW'(rd), CKW'(0));

    // Fill to capacity with the output stalled
    seq = 32'd100;
    drive_beat(seq);
    in_valid = 1'b1;
    a0 = acc_cnt;
    repeat (512) step();
    check("full_in_ready", CKW'(in_ready), CKW'(0));
    check("full_accepts", CKW'(acc_cnt - a0), CKW'(512));
    repeat (2) step();
    check("full_no_513th", CKW'(acc_cnt - a0), CKW'(512));
    csr_rd(3'd0, rd);
    check("csr_fill_512", CKW'(rd), CKW'(512));
    check("full_out_valid", CKW'(out_valid), CKW'(1));

    // Streaming from full across the pointer wrap
    out_ready = 1'b1;
    a0 = acc_cnt; p0 = pop_cnt;
    step();
    check("full_pop_ready", CKW'(in_ready), CKW'(1));
    check("full_first_acc", CKW'(acc_cnt - a0), CKW'(0));
    repeat (999) step();
    check("stream_pops", CKW'(pop_cnt - p0), CKW'(1000));
    check("stream_accepts", CKW'(acc_cnt - a0), CKW'(999));
    in_valid = 1'b0; out_ready = 1'b0;
    csr_rd(3'd0, rd);
    check("csr_fill_511", CKW'(rd), CKW'(511));

    // Random back-pressure on both sides, then drain
    a0 = acc_cnt;
    c  = 0;
    while (acc_cnt - a0 < 10000 && c < 60000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      step();
      c++;
    end
    check("rand_accepts", CKW'(acc_cnt - a0 >= 10000), CKW'(1));
    in_valid = 1'b0; out_ready = 1'b1;
    c = 0;
    while (out_valid && c < 2000) begin
      tick();
      c++;
    end
    tick();
    out_ready = 1'b0;
    check("rand_drained", CKW'(exp_q.size()), CKW'(0));
    csr_rd(3'd0, rd);
    check("csr_fill_0", CKW'(rd), CKW'(0));

    // Reset with 20 beats stored
    in_valid = 1'b1;
    a0 = acc_cnt;
    repeat (20) step();
    in_valid = 1'b0;
    check("pre_rst_accepts", CKW'(acc_cnt - a0), CKW'(20));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", CKW'(out_valid), CKW'(0));
    check("async_rst_word", out_word, CKW'(0));
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    check("rst_mid_ready", CKW'(in_ready), CKW'(1));
    csr_rd(3'd0, rd);
    check("rst_mid_csr", CKW'(rd), CKW'(0));
    check("rst_mid_valid", CKW'(out_valid), CKW'(0));

    // USE_PACKETS=0 instance: side-band not stored, data intact, depth-4 full edge
    np_in_data = 32'hCAFE_0123; np_in_sop = 1'b1; np_in_eop = 1'b1; np_in_empty = 6'd3;
    np_in_valid = 1'b1;
    tick();
    np_in_valid = 1'b0;
    tick();
    check("np_valid", CKW'(np_out_valid), CKW'(1));
    check("np_data", CKW'(np_out_data), CKW'(32'hCAFE_0123));
    check("np_sop", CKW'(np_out_sop), CKW'(0));
    check("np_eop_empty", CKW'({np_out_eop, np_out_empty}), CKW'(0));
    np_in_data = 32'h1111_2222;
    np_in_valid = 1'b1;
    repeat (3) tick();
    np_in_valid = 1'b0;
    check("np_full_ready", CKW'(np_in_ready), CKW'(0));
    np_out_ready = 1'b1;
    tick();
    np_out_ready = 1'b0;
    check("np_pop_ready", CKW'(np_in_ready), CKW'(1));
    check("np_next_data", CKW'(np_out_data), CKW'(32'h1111_2222));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
